// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, frame constants and sampling helper for the UART receive path
package uart_pkg;
   localparam int DATA_BITS = 8;
   localparam int DEF_CLOCKS_PER_PULSE = 16;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
   endfunction
endpackage

// File: rtl/receiver_if.sv
// receiver_if: serial line in, byte strobes and status out
interface receiver_if;
   import uart_pkg::*;
   logic                 rx;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 frame_err;
   logic                 rx_busy;
   modport master(output rx, input data_out, data_valid, frame_err, rx_busy);
   modport slave(input rx, output data_out, data_valid, frame_err, rx_busy);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input, reset to RST_VAL
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;
   always_ff @(posedge clk)
      if (rst) {q, meta} <= {2{RST_VAL}};
      else {q, meta} <= {meta, d};
endmodule

// File: rtl/receiver.sv
// receiver: 8N1 UART receive stage with valid/framing-error strobes
// Optional RX_MAJORITY_EN: sample points vote over a 3-deep rx_sync history
module receiver
   import uart_pkg::*;
#(
   parameter int CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE
) (
   input logic       clk,
   input logic       rst,
   receiver_if.slave bus
);
   localparam int CW = $clog2(CLOCKS_PER_PULSE);
   localparam int MID = CLOCKS_PER_PULSE / 2;
   localparam logic [CW-1:0] MID_END = CW'(MID - 1);
   localparam logic [CW-1:0] BIT_END = CW'(CLOCKS_PER_PULSE - 1);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
   rx_state_t            state, state_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [2:0]           bit_cnt, bit_n;
   logic [DATA_BITS-1:0] shift, shift_n, data_q, data_n;
   logic                 valid_q, valid_n, err_q, err_n;
   logic                 rx_sync, rx_prev, sample;
   sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(bus.rx), .q(rx_sync));
`ifdef RX_MAJORITY_EN
   logic [2:0] hist;
   always_ff @(posedge clk)
      hist <= rst ? 3'b111 : {hist[1:0], rx_sync};
   assign sample = maj3(hist);
`else
   assign sample = rx_sync;
`endif
   always_comb begin
      state_n = state;
      cnt_n   = cnt + CW'(1);
      bit_n   = bit_cnt;
      shift_n = shift;
      data_n  = data_q;
      valid_n = 1'b0;
      err_n   = 1'b0;
      case (state)
         RX_IDLE: begin
            cnt_n = '0;
            bit_n = '0;
            state_n = (!rx_sync && rx_prev) ? RX_START : RX_IDLE;
         end
         RX_START:
            if (cnt == MID_END) begin
               cnt_n = '0;
               state_n = sample ? RX_IDLE : RX_DATA;
            end
         RX_DATA:
            if (cnt == BIT_END) begin
               cnt_n = '0;
               shift_n = {sample, shift[DATA_BITS-1:1]};
               bit_n = bit_cnt + 3'd1;
               state_n = (bit_cnt == LAST_BIT) ? RX_STOP : RX_DATA;
            end
         RX_STOP:
            if (cnt == BIT_END) begin
               cnt_n = '0;
               state_n = RX_IDLE;
               valid_n = sample;
               err_n = !sample;
               data_n = sample ? shift : data_q;
            end
         default: begin
            state_n = RX_IDLE;
            cnt_n = '0;
         end
      endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         state   <= RX_IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         rx_prev <= 1'b1;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_cnt <= bit_n;
         shift   <= shift_n;
         data_q  <= data_n;
         valid_q <= valid_n;
         err_q   <= err_n;
         rx_prev <= rx_sync;
      end
   assign bus.data_out   = data_q;
   assign bus.data_valid = valid_q;
   assign bus.frame_err  = err_q;
   assign bus.rx_busy    = state != RX_IDLE;
endmodule

// File: tb/tb_receiver.sv
// tb_receiver: trace-driven bench; a software UART decoder predicts every output cycle
module tb_receiver;
   import uart_pkg::*;
   localparam int C = 16;
   localparam int MID = C / 2;
   localparam int N = 4096;
   logic clk = 1'b0;
   logic rst = 1'b1;
   receiver_if bus();
   receiver #(.CLOCKS_PER_PULSE(C)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   logic       rx_tr [N];
   logic       rst_tr[N];
   logic       e_v[N], e_e[N], e_b[N];
   logic [7:0] e_d[N];
   int len_tr = 0;
   int checks = 0;
   int errors = 0;
   int cyc = -1;
   int first_v = -1;
   int dut_errs = 0;
   logic [7:0] got_q[$];
   int t_a, t_pulse;
   task automatic check(input string name, input int n, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, n, act, exp);
      end
   endtask
   task automatic put(input logic v, input logic r, input int n);
      repeat (n) begin
         rx_tr[len_tr] = v;
         rst_tr[len_tr] = r;
         len_tr++;
      end
   endtask
   // cut < 10*C truncates the frame; glitch inverts the line at each data-bit centre
   task automatic frame(input logic [7:0] b, input logic stop, input logic glitch, input int cut);
      logic v;
      int bi;
      for (int i = 0; i < 10 * C && i < cut; i++) begin
         bi = i / C;
         v = (bi == 0) ? 1'b0 : (bi == 9) ? stop : b[bi-1];
         if (glitch && bi >= 1 && bi <= 8 && i % C == MID) v = ~v;
         put(v, 1'b0, 1);
      end
   endtask
   function automatic logic ys(input int n);
      if (n < 2) return 1'b1;
      return (rst_tr[n-1] || rst_tr[n-2]) ? 1'b1 : rx_tr[n-2];
   endfunction
   function automatic logic prv(input int n);
      return (n < 1 || rst_tr[n-1]) ? 1'b1 : ys(n - 1);
   endfunction
   function automatic logic samp(input int n);
`ifdef RX_MAJORITY_EN
      return (int'(ys(n - 1)) + int'(ys(n - 2)) + int'(ys(n - 3))) >= 2;
`else
      return ys(n);
`endif
   endfunction
   function automatic void build_model();
      logic [7:0] dq, b;
      logic good;
      int n, len, stop_at, r, last;
      dq = '0;
      n = 0;
      for (int i = 0; i < N; i++) begin
         e_v[i] = 0; e_e[i] = 0; e_b[i] = 0; e_d[i] = '0;
      end
      while (n < len_tr) begin
         if (n > 0 && rst_tr[n-1]) dq = '0;
         e_d[n] = dq;
         if ((n == 0 || !rst_tr[n-1]) && !ys(n) && prv(n)) begin
            good = !samp(n + MID);
            len = good ? MID + 9 * C : MID;
            stop_at = n + len;
            r = -1;
            for (int i = n; i <= stop_at && i < N; i++)
               if (r < 0 && rst_tr[i]) r = i;
            last = (r >= 0) ? r : stop_at;
            for (int i = n + 1; i <= last && i < N; i++) begin
               e_b[i] = 1;
               e_d[i] = dq;
            end
            if (r < 0 && good && stop_at + 1 < N) begin
               for (int k = 0; k < 8; k++) b[k] = samp(n + MID + (k + 1) * C);
               if (samp(n + MID + 9 * C)) begin
                  dq = b;
                  e_v[stop_at+1] = 1;
               end else e_e[stop_at+1] = 1;
            end
            n = last + 1;
            continue;
         end
         n++;
      end
   endfunction
   always @(negedge clk)
      if (cyc >= 0 && cyc < len_tr) begin
         check("data_valid", cyc, 8'(bus.data_valid), 8'(e_v[cyc]));
         check("frame_err", cyc, 8'(bus.frame_err), 8'(e_e[cyc]));
         check("rx_busy", cyc, 8'(bus.rx_busy), 8'(e_b[cyc]));
         check("data_out", cyc, bus.data_out, e_d[cyc]);
         if (bus.data_valid) begin
            got_q.push_back(bus.data_out);
            if (first_v < 0) first_v = cyc;
         end
         if (bus.frame_err) dut_errs++;
      end
   initial begin
      logic [7:0] exp_bytes[7];
      int nv, ne;
`ifdef RX_MAJORITY_EN
      exp_bytes = '{8'h00, 8'h55, 8'hA5, 8'hFF, 8'h12, 8'h81, 8'hC3};
`else
      exp_bytes = '{8'h00, 8'h55, 8'hA5, 8'hFF, 8'h12, 8'h81, 8'h3C};
`endif
      for (int i = 0; i < N; i++) begin
         rx_tr[i] = 1'b1;
         rst_tr[i] = 1'b0;
      end
      bus.rx = 1'b1;
      put(1'b1, 1'b1, 4);
      put(1'b1, 1'b0, 20);
      t_a = len_tr;
      frame(8'h00, 1'b1, 1'b0, 10 * C);
      frame(8'h55, 1'b1, 1'b0, 10 * C);
      frame(8'hA5, 1'b1, 1'b0, 10 * C);
      frame(8'hFF, 1'b1, 1'b0, 10 * C);
      put(1'b1, 1'b0, 20);
      frame(8'h3C, 1'b0, 1'b0, 10 * C);
      put(1'b1, 1'b0, 20);
      t_pulse = len_tr;
      put(1'b0, 1'b0, 3);
      put(1'b1, 1'b0, 30);
      frame(8'h96, 1'b1, 1'b0, 5 * C + MID);
      put(1'b1, 1'b1, 2);
      put(1'b1, 1'b0, 20);
      frame(8'h12, 1'b1, 1'b0, 10 * C);
      put(1'b1, 1'b0, 20);
      put(1'b0, 1'b0, 30 * C);
      put(1'b1, 1'b0, 20);
      frame(8'h81, 1'b1, 1'b0, 10 * C);
      put(1'b1, 1'b0, 20);
      frame(8'hC3, 1'b1, 1'b1, 10 * C);
      put(1'b1, 1'b0, 40);
      build_model();
      nv = 0;
      ne = 0;
      for (int i = 0; i < N; i++) begin
         nv += int'(e_v[i]);
         ne += int'(e_e[i]);
      end
      check("model_first_strobe", t_a + 155, 8'(e_v[t_a+155]), 8'd1);
      check("model_second_byte", t_a + 315, e_d[t_a+315], 8'h55);
      check("model_valid_count", 0, 8'(nv), 8'd7);
      check("model_err_count", 0, 8'(ne), 8'd2);
      check("model_pulse_busy", t_pulse + 3, 8'(e_b[t_pulse+3]), 8'd1);
      check("model_pulse_idle", t_pulse + 11, 8'(e_b[t_pulse+11]), 8'd0);
      for (int n = 0; n < len_tr; n++) begin
         @(posedge clk);
         #1;
         cyc = n;
         bus.rx = rx_tr[n];
         rst = rst_tr[n];
      end
      @(posedge clk);
      #1;
      cyc = len_tr;
      check("first_strobe_offset", first_v, 8'(first_v - t_a), 8'd155);
      check("valid_strobe_count", 0, 8'(got_q.size()), 8'd7);
      check("frame_err_count", 0, 8'(dut_errs), 8'd2);
      for (int i = 0; i < 7; i++)
         check("byte_sequence", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_bytes[i]);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
